// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared BCD constants, FSM state encoding and digit-validity helper
// for the BCD datapath.
package bcd_pkg;

  localparam int         BCD_W       = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_CORR_TH = 4'd8;
  localparam logic [3:0] BCD_CORR    = 4'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake bundle between a requester (master) and
// the BCD-to-binary converter (slave).
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) ();

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  flag;

  modport master (output start, bcd_in, input busy, done, bin_out, flag);
  modport slave  (input start, bcd_in, output busy, done, bin_out, flag);

endinterface

// File: rtl/bcd_to_bin_seq_digit_corr.sv
// Reverse double-dabble digit correction: a digit of 8 or more after the
// right shift has 3 subtracted; the result is always >= 5, so no borrow.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_CORR_TH) ? (i_digit - BCD_CORR) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one bit per clock via reverse
// double-dabble, with start/busy/done handshake and invalid-digit flag.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic             clk,
  input  logic             reset,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int S_W   = BCD_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  logic [1:0]       r_state;
  logic [S_W-1:0]   r_s;
  logic [BIN_W-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BIN_W-1:0] r_bin;
  logic             r_flag;

  logic [S_W-1:0]   w_s_sh;
  logic [S_W-1:0]   w_s_corr;
  logic [BIN_W-1:0] w_b_sh;
  logic             w_all_valid;

  // {S,B} shifted right by one: S LSB moves into B MSB
  assign w_s_sh = {1'b0, r_s[S_W-1:1]};
  assign w_b_sh = {r_s[0], r_b[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .i_digit (w_s_sh[g*BCD_W +: BCD_W]),
      .o_digit (w_s_corr[g*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    w_all_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(bus.bcd_in[i*BCD_W +: BCD_W])) begin
        w_all_valid = 1'b0;
      end else begin
        w_all_valid = w_all_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bin   <= '0;
      r_flag  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_s   <= bus.bcd_in;
            r_b   <= '0;
            r_cnt <= '0;
            r_bin <= '0;
            if (w_all_valid) begin
              r_state <= ST_CONV;
              r_busy  <= 1'b1;
              r_flag  <= 1'b0;
            end else begin
              // invalid digit: skip conversion, report immediately
              r_state <= ST_DONE;
              r_flag  <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end
        ST_CONV: begin
          r_s   <= w_s_corr;
          r_b   <= w_b_sh;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_bin   <= w_b_sh;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bin_out = r_bin;
  assign bus.flag    = r_flag;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq (DIGITS=2, BIN_W=7): vector table,
// multi-cycle corner cases and a full two-digit sweep.
module tb_bcd_to_bin_seq;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bcd_to_bin_seq_if #(.DIGITS(2), .BIN_W(7)) bus ();

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bcd;
    int         exp_bin;
    int         exp_flag;
    int         exp_lat;
    int         exp_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start with bcd, then count negedges until done (bounded)
  task automatic run_one(input logic [7:0] bcd, output int lat, output int busy_cnt,
                         output int timeout);
    @(negedge clk);
    bus.bcd_in = bcd;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    timeout = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        timeout = 0;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, to, seen, gap;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = 8'h00;

    vecs[0] = '{8'h00, 0,  0, 8, 7};
    vecs[1] = '{8'h99, 99, 0, 8, 7};
    vecs[2] = '{8'h42, 42, 0, 8, 7};
    vecs[3] = '{8'h4A, 0,  1, 1, 0};
    vecs[4] = '{8'h37, 37, 0, 8, 7};
    vecs[5] = '{8'hF0, 0,  1, 1, 0};
    vecs[6] = '{8'h09, 9,  0, 8, 7};
    vecs[7] = '{8'h90, 90, 0, 8, 7};
    vecs[8] = '{8'h59, 59, 0, 8, 7};
    vecs[9] = '{8'h88, 88, 0, 8, 7};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_bin",  int'(bus.bin_out), 0);
    chk("reset_flag", int'(bus.flag), 0);

    for (int v = 0; v < 10; v++) begin
      run_one(vecs[v].bcd, lat, bc, to);
      chk("vec_timeout", to, 0);
      chk("vec_latency", lat, vecs[v].exp_lat);
      chk("vec_busy_cycles", bc, vecs[v].exp_busy);
      chk("vec_bin", int'(bus.bin_out), vecs[v].exp_bin);
      chk("vec_flag", int'(bus.flag), vecs[v].exp_flag);
      @(negedge clk);
      chk("vec_done_one_cycle", int'(bus.done), 0);
      chk("vec_bin_hold", int'(bus.bin_out), vecs[v].exp_bin);
    end

    // start re-pulsed mid-conversion with new data must be ignored
    @(negedge clk);
    bus.bcd_in = 8'h37;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.bcd_in = 8'h55;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 4;
    to = 1;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) begin
        to = 0;
        break;
      end
      @(negedge clk);
      lat++;
    end
    chk("ignore_timeout", to, 0);
    chk("ignore_latency", lat, 8);
    chk("ignore_bin", int'(bus.bin_out), 37);
    repeat (3) @(negedge clk);
    chk("ignore_no_requeue", int'(bus.busy), 0);

    // synchronous reset during CONV aborts with no done pulse
    @(negedge clk);
    bus.bcd_in = 8'h64;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", int'(bus.busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_bin",  int'(bus.bin_out), 0);
    chk("abort_flag", int'(bus.flag), 0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done || bus.busy) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", seen, 0);

    // start held high: restart on every IDLE re-entry, period BIN_W+2
    bus.bcd_in = 8'h21;
    bus.start  = 1'b1;
    to = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        to = 0;
        break;
      end
    end
    chk("held_first_timeout", to, 0);
    chk("held_first_bin", int'(bus.bin_out), 21);
    gap = 0;
    to = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      gap++;
      if (bus.done) begin
        to = 0;
        break;
      end
    end
    bus.start = 1'b0;
    chk("held_second_timeout", to, 0);
    chk("held_period", gap, 9);
    chk("held_second_bin", int'(bus.bin_out), 21);
    repeat (3) @(negedge clk);

    // full two-digit sweep including invalid nibbles
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [7:0] b;
        int exp_bin;
        int exp_flag;
        b = {i[3:0], j[3:0]};
        exp_flag = (i > 9 || j > 9) ? 1 : 0;
        exp_bin  = exp_flag ? 0 : 10 * i + j;
        run_one(b, lat, bc, to);
        chk("sweep_timeout", to, 0);
        chk("sweep_bin", int'(bus.bin_out), exp_bin);
        chk("sweep_flag", int'(bus.flag), exp_flag);
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
